// File: rtl/sw_led_pio_if.sv
// Avalon-MM slave bus plus interrupt line for the switch/LED PIO.
interface sw_led_pio_if;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic        irq;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid, irq
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid, irq
  );
endinterface

// File: rtl/sw_led_pio.sv
// Switch/LED PIO: synchronized and debounced switches, LED register,
// latched edge flags with maskable level interrupt, fixed latency-1 reads.
module sw_led_pio #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  sw_led_pio_if.slave      bus,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] led_out
);

  // Counter stops at DEBOUNCE_CYCLES-1: the edge that would reach the limit commits the new value.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [WIDTH-1:0] r_db;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_led;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [31:0]      r_rdata_p1;
  logic             r_rdv_p1;

  logic [WIDTH-1:0] w_db_nxt;
  logic [WIDTH-1:0] w_clr;
  logic [31:0]      w_rd_sel;
  logic             w_wr_led;
  logic             w_wr_mask;
  logic             w_unused_wd;

  assign w_wr_led    = bus.write && (bus.address == 2'd1);
  assign w_wr_mask   = bus.write && (bus.address == 2'd2);
  assign w_unused_wd = ^bus.writedata;

  always_comb begin
    w_db_nxt = r_db;
    for (int i = 0; i < WIDTH; i++) begin
      if ((r_sync2[i] != r_db[i]) && (r_cnt[i] == CNT_LAST))
        w_db_nxt[i] = r_sync2[i];
    end
  end

  always_comb begin
    w_clr = '0;
    if (bus.write && (bus.address == 2'd3))
      w_clr = bus.writedata[WIDTH-1:0];
  end

  always_comb begin
    w_rd_sel = '0;
    case (bus.address)
      2'd0:    w_rd_sel = 32'(r_db);
      2'd1:    w_rd_sel = 32'(r_led);
      2'd2:    w_rd_sel = 32'(r_mask);
      default: w_rd_sel = 32'(r_edge);
    endcase
  end

  // Input stage: two-flop synchronizer and per-bit debounce counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= sw_in;
      r_sync2 <= r_sync1;
      r_db    <= w_db_nxt;
      for (int i = 0; i < WIDTH; i++) begin
        if ((r_sync2[i] == r_db[i]) || (r_cnt[i] == CNT_LAST))
          r_cnt[i] <= '0;
        else
          r_cnt[i] <= r_cnt[i] + 1'b1;
      end
    end
  end

  // Register file; a new debounced change outranks a same-edge clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led  <= '0;
      r_mask <= '0;
      r_edge <= '0;
    end else begin
      if (w_wr_led)  r_led  <= bus.writedata[WIDTH-1:0];
      if (w_wr_mask) r_mask <= bus.writedata[WIDTH-1:0];
      r_edge <= (r_edge & ~w_clr) | (w_db_nxt ^ r_db);
    end
  end

  // Read response stage: captures pre-write contents, one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rdata_p1 <= '0;
      r_rdv_p1   <= 1'b0;
    end else begin
      r_rdv_p1   <= bus.read;
      r_rdata_p1 <= bus.read ? w_rd_sel : 32'd0;
    end
  end

  assign bus.readdata      = r_rdata_p1;
  assign bus.readdatavalid = r_rdv_p1;
  assign bus.irq           = |(r_edge & r_mask);
  assign led_out           = r_led;

endmodule

// File: tb/tb_sw_led_pio.sv
// Bench for sw_led_pio: directed scenarios plus randomized traffic against a window-based reference model.
module tb_sw_led_pio;
  localparam int W = 10;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw_in;
  logic [W-1:0] led_out;

  sw_led_pio_if bus();

  sw_led_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .sw_in   (sw_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [W-1:0] m_led, m_mask, m_edge, m_db;
  logic [31:0]  m_rdata;
  logic         m_rdv;
  logic [W-1:0] pipe[$];
  logic [W-1:0] chist[$];
  int           last_upd[W];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] msel(input logic [1:0] a);
    case (a)
      2'd0:    return 32'(m_db);
      2'd1:    return 32'(m_led);
      2'd2:    return 32'(m_mask);
      default: return 32'(m_edge);
    endcase
  endfunction

  task automatic model_reset();
    m_led = '0; m_mask = '0; m_edge = '0; m_db = '0;
    m_rdata = '0; m_rdv = 1'b0;
    pipe.delete(); pipe.push_back('0); pipe.push_back('0);
    chist.delete();
    for (int i = 0; i < W; i++) last_upd[i] = 0;
  endtask

  // A debounced bit flips once the last D synchronized samples since its
  // previous flip all disagree with it; sync output lags sw_in by two edges.
  task automatic model_step(input logic rd, input logic wr, input logic [1:0] a,
                            input logic [31:0] wd, input logic [W-1:0] sw);
    logic [W-1:0] cons, chg, clr, v;
    int n;
    bit all_diff;
    m_rdv   = rd;
    m_rdata = rd ? msel(a) : 32'd0;
    cons = pipe[0];
    void'(pipe.pop_front());
    pipe.push_back(sw);
    chist.push_back(cons);
    n   = chist.size();
    chg = '0;
    for (int i = 0; i < W; i++) begin
      if (n - last_upd[i] >= D) begin
        all_diff = 1'b1;
        for (int k = n - D; k < n; k++) begin
          v = chist[k];
          if (v[i] == m_db[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          chg[i]      = 1'b1;
          last_upd[i] = n;
        end
      end
    end
    m_db = m_db ^ chg;
    clr  = (wr && a == 2'd3) ? wd[W-1:0] : '0;
    if (wr && a == 2'd1) m_led  = wd[W-1:0];
    if (wr && a == 2'd2) m_mask = wd[W-1:0];
    m_edge = (m_edge & ~clr) | chg;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (reset) model_reset();
      else model_step(bus.read, bus.write, bus.address, bus.writedata, sw_in);
      @(negedge clk);
      if (reset) model_reset();
      chk("led_out", 32'(led_out), 32'(m_led));
      chk("readdata", bus.readdata, m_rdata);
      chk("readdatavalid", 32'(bus.readdatavalid), 32'(m_rdv));
      chk("irq", 32'(bus.irq), 32'(|(m_edge & m_mask)));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    bus.write = 1'b1; bus.address = a; bus.writedata = d;
    cyc();
    bus.write = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    bus.read = 1'b1; bus.address = a;
    cyc();
    bus.read = 1'b0;
    chk("rdv_pulse", 32'(bus.readdatavalid), 32'd1);
    d = bus.readdata;
  endtask

  logic [31:0]  d;
  logic [W-1:0] one;

  initial begin
    reset = 1'b1; bus.read = 1'b0; bus.write = 1'b0;
    bus.address = '0; bus.writedata = '0; sw_in = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_led", 32'(led_out), 32'd0);
    chk("rst_irq", 32'(bus.irq), 32'd0);
    chk("rst_rdv", 32'(bus.readdatavalid), 32'd0);
    chk("rst_rdata", bus.readdata, 32'd0);

    bus_write(2'd1, 32'h2A5);
    chk("led_after_write", 32'(led_out), 32'h2A5);
    bus_read(2'd1, d);
    chk("led_readback", d, 32'h0000_02A5);

    // Three-clock glitch on bit 0 must not be accepted
    sw_in = 10'h001;
    repeat (3) cyc();
    sw_in = '0;
    repeat (8) cyc();
    bus_read(2'd0, d); chk("glitch_sw", d, 32'h0);
    bus_read(2'd3, d); chk("glitch_edge", d, 32'h0);
    chk("glitch_irq", 32'(bus.irq), 32'd0);

    bus_write(2'd2, 32'h008);
    sw_in = 10'h008;
    repeat (5) cyc();
    chk("irq_before_debounce", 32'(bus.irq), 32'd0);
    cyc();
    chk("irq_after_debounce", 32'(bus.irq), 32'd1);
    bus_read(2'd0, d); chk("sw_rise", d, 32'h008);
    bus_read(2'd3, d); chk("edge_rise", d, 32'h008);

    bus_write(2'd3, 32'h008);
    chk("irq_cleared", 32'(bus.irq), 32'd0);
    sw_in = '0;
    repeat (5) cyc();
    bus_write(2'd3, 32'h008);
    bus_read(2'd3, d); chk("edge_set_wins", d, 32'h008);
    chk("irq_set_wins", 32'(bus.irq), 32'd1);
    bus_write(2'd3, 32'h008);
    bus_read(2'd3, d); chk("edge_late_clear", d, 32'h0);
    chk("irq_late_clear", 32'(bus.irq), 32'd0);

    bus_write(2'd1, 32'h0FF);
    bus.read = 1'b1; bus.write = 1'b1; bus.address = 2'd1; bus.writedata = 32'h155;
    cyc();
    bus.read = 1'b0; bus.write = 1'b0;
    chk("rw_rdv", 32'(bus.readdatavalid), 32'd1);
    chk("rw_old_value", bus.readdata, 32'h0000_00FF);
    chk("rw_led_new", 32'(led_out), 32'h155);

    bus_write(2'd1, 32'h3FF);
    bus_write(2'd2, 32'h001);
    sw_in = 10'h001;
    repeat (8) cyc();
    chk("irq_before_reset", 32'(bus.irq), 32'd1);
    bus.read = 1'b1; bus.address = 2'd1;
    #2 reset = 1'b1;
    #1;
    chk("rst_led_async", 32'(led_out), 32'd0);
    chk("rst_irq_async", 32'(bus.irq), 32'd0);
    cyc();
    bus.read = 1'b0;
    chk("rst_no_rdv", 32'(bus.readdatavalid), 32'd0);
    chk("rst_no_rdata", bus.readdata, 32'd0);
    cyc();
    reset = 1'b0;

    // Switch held high through reset: accepted 2 + D edges after release
    repeat (5) cyc();
    bus_read(2'd0, d); chk("sw_post_reset_early", d, 32'h0);
    bus_read(2'd0, d); chk("sw_post_reset_rise", d, 32'h001);
    bus_read(2'd3, d); chk("edge_post_reset", d, 32'h001);

    for (int it = 0; it < 3000; it++) begin
      bus.read      = ($urandom_range(0, 2) == 0);
      bus.write     = ($urandom_range(0, 3) == 0);
      bus.address   = 2'($urandom_range(0, 3));
      bus.writedata = $urandom;
      if ($urandom_range(0, 4) == 0) begin
        one = '0;
        one[$urandom_range(0, W - 1)] = 1'b1;
        sw_in = sw_in ^ one;
      end
      cyc();
      if (it == 1500) begin
        #2 reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
      end
    end
    bus.read = 1'b0; bus.write = 1'b0;
    repeat (2) cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
